time_set_ctrl: RTL and testbench
================================

// Module: time_set_ctrl
// PURPOSE
//  Front-end control stage for the HH:MM:SS clock. Turns the one free push-button (KEY[1]) into
//  set-mode control for the second/minute/hour counter chain it feeds. Outputs: run gate for the
//  1 s strobe, one-cycle increment strobes for the hour/minute counters, a seconds-clear strobe
//  and a per-digit blank mask for the SEG7 stage. Sits between the board key and the counters.
// PARAMETERS
//  DEB_CYCLES    1_000_000   cycles the synced key must be stable to be accepted (20 ms @ 50 MHz)
//  LONG_CYCLES   50_000_000  cycles of held press that make a long press (1 s)
//  BLINK_CYCLES  12_500_000  half-period of edit-field blink (250 ms); used only with BLINK_EN
// PORTS
//  iClk      in   1  system clock (MAX10_CLK2_50)
//  iRst      in   1  asynchronous active-low reset
//  iKey      in   1  raw key, active-low, asynchronous to iClk
//  oRun      out  1  1 = RUN mode; AND with the 1 s strobe upstream of the seconds counter
//  oIncHour  out  1  one-cycle pulse: increment hour counter
//  oIncMin   out  1  one-cycle pulse: increment minute counter
//  oSecClr   out  1  one-cycle pulse: clear seconds on return to RUN
//  oMode     out  2  current mode_e
//  oBlank    out  6  per-digit blank, bit n = HEXn (1:0 sec, 3:2 min, 5:4 hour)
// BEHAVIOUR
//  - One clock; reset asynchronous active-low. Reset: oRun=1, oMode=RUN, all pulses 0, oBlank=0,
//    sync/stable key=1 (released), all counters 0. Reset mid-press aborts the press; a key still
//    held after reset release is a fresh press once debounced.
//  - iKey through 2-flop synchroniser. Debounce counter clears whenever synced != stable; when
//    it reaches DEB_CYCLES-1 stable <= synced. Press = stable 1->0, release = stable 0->1.
//  - Hold counter runs while stable==0, saturates at LONG_CYCLES-1. Long event: one pulse in the
//    cycle the count reaches LONG_CYCLES-1 (while still held). Short event: one pulse in the cycle
//    after release, only if no long event fired in that press. Max one event per press.
//  - FSM (registered, mode_e): RUN=2'b00, SET_HOUR=2'b01, SET_MIN=2'b10; 2'b11 -> RUN next cycle.
//    long: RUN->SET_HOUR->SET_MIN->RUN. short: SET_HOUR -> oIncHour, SET_MIN -> oIncMin,
//    RUN -> ignored. Strobes are registered: asserted 1 cycle after the event cycle, 1 cycle wide.
//  - oRun = (mode==RUN), registered with mode. Outside RUN the seconds chain is frozen.
//  - oSecClr pulses in the first cycle of RUN after SET_MIN->RUN only. Not emitted at reset.
//  - Counter wrap (23->0, 59->0) belongs to the counters. This block never saturates or limits
//    increments.
// CONFIGURATION
//  BLINK_EN defined: blink phase counter toggles phase every BLINK_CYCLES. Phase 0 = visible.
//    Phase counter and phase cleared on every mode change and every inc strobe, so the new value
//    shows at once. oBlank[5:4]=phase in SET_HOUR, oBlank[3:2]=phase in SET_MIN, else 0.
//  BLINK_EN undefined: no blink logic; oBlank tied to 6'b0. All other behaviour identical.
// STRUCTURE
//  - clock_pkg: typedef enum logic[1:0] mode_e {RUN, SET_HOUR, SET_MIN}; localparams for HEX digit
//    indices (SEC_LO=0 .. HOUR_HI=5).
//  - Sub-module key_debounce (iClk, iRst, iKey -> oShort, oLong): synchroniser, debounce and
//    press classification. time_set_ctrl holds the FSM, strobes and blink.
// TESTING (bench params DEB_CYCLES=4, LONG_CYCLES=20, BLINK_CYCLES=8)
//  1 Reset, key high 50 cycles -> oMode=RUN, oRun=1, no pulses, oBlank=0.
//  2 Key bounces 0/1 every 2 cycles for 20 cycles, then settles high -> no event, mode stays RUN.
//  3 Press held 30 cycles -> exactly one long, mode SET_HOUR, oRun=0. Release -> no short/inc.
//  4 In SET_HOUR, 3 presses of 8 cycles -> exactly 3 oIncHour pulses, each 1 cycle, 0 oIncMin.
//  5 Long to SET_MIN, 2 short -> 2 oIncMin. Long -> RUN, oSecClr 1 cycle, oRun=1.
//  6 BLINK_EN in SET_MIN -> oBlank=6'b001100 / 6'b0 alternating every 8 cycles; phase restarts
//    visible after inc; assert iRst mid-press -> all outputs to reset values at once.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types for the HH:MM:SS clock front end: set-mode encoding
// and the HEX digit indices used by the per-digit blank mask.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } mode_e;

  localparam int SEC_LO  = 0;
  localparam int SEC_HI  = 1;
  localparam int MIN_LO  = 2;
  localparam int MIN_HI  = 3;
  localparam int HOUR_LO = 4;
  localparam int HOUR_HI = 5;

endpackage

// File: rtl/key_debounce.sv
// Key front end: 2-flop synchroniser, debounce and short/long press
// classification. Ports: iClk, iRst (async low), iKey (raw, active-low)
//   -> oShort, oLong (one-cycle events, at most one per press).
module key_debounce #(
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int LONG_CYCLES = 50_000_000
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iKey,
  output logic oShort,
  output logic oLong
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 2);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_stable_d;
  logic [DW-1:0] r_deb_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic          r_long;
  logic          r_long_seen;
  logic          w_press;
  logic          w_rel;

  assign w_press = r_stable_d & ~r_stable;
  assign w_rel   = ~r_stable_d & r_stable;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_stable    <= 1'b1;
      r_stable_d  <= 1'b1;
      r_deb_cnt   <= '0;
      r_hold_cnt  <= '0;
      r_long      <= 1'b0;
      r_long_seen <= 1'b0;
    end else begin
      r_sync1    <= iKey;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      // count only while the synced key disagrees; any bounce back restarts
      if (r_sync2 == r_stable) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_MAX) begin
        r_deb_cnt <= '0;
        r_stable  <= r_sync2;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
      if (r_stable) begin
        r_hold_cnt <= '0;
      end else if (r_hold_cnt != HOLD_MAX) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
      // high exactly in the cycle the hold count lands on its maximum
      r_long <= ~r_stable & (r_hold_cnt == HOLD_PRE);
      if (w_press) begin
        r_long_seen <= 1'b0;
      end else if (r_long) begin
        r_long_seen <= 1'b1;
      end
    end
  end

  assign oLong  = r_long;
  // r_long term covers a long event landing in the release cycle
  assign oShort = w_rel & ~r_long_seen & ~r_long;

endmodule

// File: rtl/time_set_ctrl.sv
// Set-mode control for the HH:MM:SS counter chain: run gate, hour/minute
// increment strobes, seconds clear and per-digit blank mask.
// Ports: iClk, iRst (async low), iKey -> oRun, oIncHour, oIncMin,
//   oSecClr, oMode[1:0], oBlank[5:0]. Define BLINK_EN for edit blink.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEB_CYCLES   = 1_000_000,
  parameter int LONG_CYCLES  = 50_000_000,
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iKey,
  output logic       oRun,
  output logic       oIncHour,
  output logic       oIncMin,
  output logic       oSecClr,
  output logic [1:0] oMode,
  output logic [5:0] oBlank
);

  logic       w_short;
  logic       w_long;
  logic [1:0] r_mode;
  logic [1:0] w_next;
  logic       r_run;
  logic       r_inc_h;
  logic       r_inc_m;
  logic       r_clr;
  logic       w_inc_h;
  logic       w_inc_m;
  logic       w_clr;

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .LONG_CYCLES(LONG_CYCLES)
  ) u_key (
    .iClk  (iClk),
    .iRst  (iRst),
    .iKey  (iKey),
    .oShort(w_short),
    .oLong (w_long)
  );

  always_comb begin
    w_next  = r_mode;
    w_inc_h = 1'b0;
    w_inc_m = 1'b0;
    w_clr   = 1'b0;
    case (r_mode)
      RUN: begin
        if (w_long) w_next = SET_HOUR;
      end
      SET_HOUR: begin
        if (w_long)       w_next  = SET_MIN;
        else if (w_short) w_inc_h = 1'b1;
      end
      SET_MIN: begin
        if (w_long) begin
          w_next = RUN;
          w_clr  = 1'b1;
        end else if (w_short) begin
          w_inc_m = 1'b1;
        end
      end
      default: w_next = RUN;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_mode  <= RUN;
      r_run   <= 1'b1;
      r_inc_h <= 1'b0;
      r_inc_m <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      r_mode  <= w_next;
      r_run   <= (w_next == RUN);
      r_inc_h <= w_inc_h;
      r_inc_m <= w_inc_m;
      r_clr   <= w_clr;
    end
  end

  assign oMode    = r_mode;
  assign oRun     = r_run;
  assign oIncHour = r_inc_h;
  assign oIncMin  = r_inc_m;
  assign oSecClr  = r_clr;

`ifdef BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] r_bcnt;
  logic          r_phase;
  logic          w_restart;

  // restart visible on the same edge the new mode/strobe is registered
  assign w_restart = (w_next != r_mode) | w_inc_h | w_inc_m;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_restart) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (r_bcnt == BLINK_MAX) begin
      r_bcnt  <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_bcnt <= r_bcnt + 1'b1;
    end
  end

  always_comb begin
    oBlank = '0;
    if (r_mode == SET_HOUR) begin
      oBlank[HOUR_LO] = r_phase;
      oBlank[HOUR_HI] = r_phase;
    end else if (r_mode == SET_MIN) begin
      oBlank[MIN_LO] = r_phase;
      oBlank[MIN_HI] = r_phase;
    end
  end
`else
  assign oBlank = '0;
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: pulse scoreboard plus mode/blank checks.
// Expected pulses are queued with each stimulus step and popped on output.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key;
  logic       o_run;
  logic       o_inc_h;
  logic       o_inc_m;
  logic       o_clr;
  logic [1:0] o_mode;
  logic [5:0] o_blank;

  int n_chk  = 0;
  int n_fail = 0;
  int n_hour = 0;
  logic [2:0] sb_q[$];

  always #5 clk = ~clk;

  time_set_ctrl #(
    .DEB_CYCLES  (4),
    .LONG_CYCLES (20),
    .BLINK_CYCLES(8)
  ) dut (
    .iClk    (clk),
    .iRst    (rst_n),
    .iKey    (key),
    .oRun    (o_run),
    .oIncHour(o_inc_h),
    .oIncMin (o_inc_m),
    .oSecClr (o_clr),
    .oMode   (o_mode),
    .oBlank  (o_blank)
  );

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic press(input int n);
    key = 1'b0;
    repeat (n) @(negedge clk);
    key = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // pulse monitor: {clr, min, hour}
  initial begin
    logic [2:0] obs;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        obs = {o_clr, o_inc_m, o_inc_h};
        if (o_inc_h === 1'b1) n_hour++;
        if (obs != 3'b000) begin
          if (sb_q.size() == 0) chk("sb_unexpected", 8'(obs), 8'h0);
          else                  chk("sb_event", 8'(obs), 8'(sb_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int t;
    rst_n = 1'b0;
    key   = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("rst_mode", 8'(o_mode), 8'h0);
    chk("rst_run", 8'(o_run), 8'h1);
    chk("rst_blank", 8'(o_blank), 8'h0);

    // bounce never survives debounce
    for (int i = 0; i < 5; i++) begin
      key = 1'b0;
      repeat (2) @(negedge clk);
      key = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("bounce_mode", 8'(o_mode), 8'h0);
    chk("bounce_run", 8'(o_run), 8'h1);

    press(30);
    chk("long1_mode", 8'(o_mode), 8'h1);
    chk("long1_run", 8'(o_run), 8'h0);

    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(3'b001);
      press(8);
    end
    chk("hour_cnt", 8'(n_hour), 8'd3);
    chk("hour_mode", 8'(o_mode), 8'h1);

    press(30);
    chk("long2_mode", 8'(o_mode), 8'h2);
    chk("long2_run", 8'(o_run), 8'h0);
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(3'b010);
      press(8);
    end
    sb_q.push_back(3'b100);
    press(30);
    chk("long3_mode", 8'(o_mode), 8'h0);
    chk("long3_run", 8'(o_run), 8'h1);
    chk("sb_drain1", 8'(sb_q.size()), 8'h0);

`ifdef BLINK_EN
    press(30);
    chk("bl_hour_mode", 8'(o_mode), 8'h1);
    key = 1'b0;
    t = 0;
    while (o_mode !== 2'd2 && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("bl_enter", 8'(o_mode), 8'h2);
    for (int i = 0; i < 32; i++) begin
      chk("bl_phase", 8'(o_blank), ((i / 8) % 2 == 1) ? 8'h0c : 8'h00);
      @(negedge clk);
    end
    key = 1'b1;
    repeat (12) @(negedge clk);
    sb_q.push_back(3'b010);
    key = 1'b0;
    repeat (8) @(negedge clk);
    key = 1'b1;
    t = 0;
    while (o_inc_m !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bl_inc_seen", 8'(o_inc_m), 8'h1);
    for (int i = 0; i < 9; i++) begin
      chk("bl_after_inc", 8'(o_blank), (i == 8) ? 8'h0c : 8'h00);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    sb_q.push_back(3'b100);
    press(30);
    chk("bl_exit_mode", 8'(o_mode), 8'h0);
    chk("bl_exit_blank", 8'(o_blank), 8'h0);
`endif

    // reset mid-press from SET_HOUR
    press(30);
    chk("pre_rst_mode", 8'(o_mode), 8'h1);
    key = 1'b0;
    repeat (10) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_mode", 8'(o_mode), 8'h0);
    chk("arst_run", 8'(o_run), 8'h1);
    chk("arst_blank", 8'(o_blank), 8'h0);
    chk("arst_pulses", 8'({o_clr, o_inc_m, o_inc_h}), 8'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // key still held: fresh press, long again
    repeat (35) @(negedge clk);
    chk("fresh_mode", 8'(o_mode), 8'h1);
    key = 1'b1;
    repeat (12) @(negedge clk);
    chk("fresh_rel_mode", 8'(o_mode), 8'h1);
    chk("fresh_rel_run", 8'(o_run), 8'h0);
    chk("sb_drain2", 8'(sb_q.size()), 8'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
